// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
//   state_e  : FSM state encoding, also exported on o_state for debug
//   STATE_W  : width of the state encoding
//   max_int  : helper used to size the shared hold/stagger counter
package reset_sequencer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REL   = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset deassertion synchronizer: a STAGES-deep flop chain that is
// asynchronously set by i_rst and shifts zeros in once i_rst is low.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset (sets the whole chain)
//   o_rst_sync : reset asserted immediately, released STAGES edges after i_rst falls
module reset_sequencer_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst_sync
);

  logic [STAGES-1:0] chain_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], 1'b0};
    end
  end

  assign o_rst_sync = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: turns a raw asynchronous reset or a software request into
// N_OUT active-low resets that assert together and release one by one, low
// bit first, after a hold period.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_sw_rst_req : software reset request (level; rising edge acted on in RUN)
//   o_rstn       : sequenced active-low resets, bit j feeds downstream domain j
//   o_sw_rst_ack : one-cycle pulse when a software-initiated sequence completes
//   o_busy       : high whenever the FSM is not in RUN
//   o_state      : current FSM state (debug)
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int N_OUT       = 3,
  parameter int STAGGER     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sw_rst_req,
  output logic [N_OUT-1:0]   o_rstn,
  output logic               o_sw_rst_ack,
  output logic               o_busy,
  output logic [STATE_W-1:0] o_state
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER) + 1);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] BIT0      = N_OUT'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_OUT-1:0]   rstn_q, rstn_d;
  logic               sw_seq_q, sw_seq_d;   // current sequence was software-initiated
  logic               ack_q, ack_d;
  logic               req_q;
  logic               sync_rst;
  logic               sw_edge;
  logic               release_now;

  reset_sequencer_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_rst_sync (sync_rst)
  );

  assign sw_edge = i_sw_rst_req & ~req_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      idx_q    <= '0;
      rstn_q   <= '0;
      sw_seq_q <= 1'b0;
      ack_q    <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rstn_q   <= rstn_d;
      sw_seq_q <= sw_seq_d;
      ack_q    <= ack_d;
      // Tracks the request level in every state, so edges seen outside RUN
      // are consumed rather than queued.
      req_q    <= i_sw_rst_req;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rstn_d      = rstn_q;
    sw_seq_d    = sw_seq_q;
    ack_d       = 1'b0;
    release_now = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (!sync_rst) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) release_now = 1'b1;
        else                    cnt_d = cnt_q + 1'b1;
      end
      ST_REL: begin
        if (cnt_q == STAG_LAST) release_now = 1'b1;
        else                    cnt_d = cnt_q + 1'b1;
      end
      ST_RUN: begin
        // Software path skips the synchronizer: the request is already in
        // the clock domain.
        if (sw_edge) begin
          state_d  = ST_HOLD;
          cnt_d    = '0;
          idx_d    = '0;
          rstn_d   = '0;
          sw_seq_d = 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase

    // Releases are cumulative: shifting a 1 in from the bottom keeps every
    // already-released bit high and frees the next one up.
    if (release_now) begin
      rstn_d = (rstn_q << 1) | BIT0;
      cnt_d  = '0;
      if (idx_q == IDX_LAST) begin
        state_d  = ST_RUN;
        ack_d    = sw_seq_q;
        sw_seq_d = 1'b0;
      end else begin
        state_d = ST_REL;
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  assign o_rstn       = rstn_q;
  assign o_sw_rst_ack = ack_q;
  assign o_busy       = (state_q != ST_RUN);
  assign o_state      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default configuration plus a minimal
// HOLD_CYCLES=1 / N_OUT=1 / STAGGER=1 instance sharing the same i_rst.
module tb_reset_sequencer;

  localparam int H = 4;
  localparam int S = 2;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       req_min = 1'b0;

  logic [2:0] rstn;
  logic       ack, busy;
  logic [1:0] st;

  logic [0:0] rstn_m;
  logic       ack_m, busy_m;
  logic [1:0] st_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES (2),
    .HOLD_CYCLES (H),
    .N_OUT       (N),
    .STAGGER     (S)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sw_rst_req (req),
    .o_rstn       (rstn),
    .o_sw_rst_ack (ack),
    .o_busy       (busy),
    .o_state      (st)
  );

  reset_sequencer #(
    .SYNC_STAGES (2),
    .HOLD_CYCLES (1),
    .N_OUT       (1),
    .STAGGER     (1)
  ) dut_min (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sw_rst_req (req_min),
    .o_rstn       (rstn_m),
    .o_sw_rst_ack (ack_m),
    .o_busy       (busy_m),
    .o_state      (st_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, " rstn"},   32'(rstn),   32'd0);
    check({tag, " state"},  32'(st),     32'd0);
    check({tag, " busy"},   32'(busy),   32'd1);
    check({tag, " ack"},    32'(ack),    32'd0);
    check({tag, " rstn_m"}, 32'(rstn_m), 32'd0);
    check({tag, " st_m"},   32'(st_m),   32'd0);
  endtask

  // d is the edge number relative to k (the edge that enters HOLD).
  // req is driven high before edges listed in pa/pb/pc, or throughout if hold.
  task automatic run_seq(input int first_d, input int last_d, input bit sw, input bit hold,
                         input int pa, input int pb, input int pc, input string tag);
    int         c;
    logic [2:0] e_rstn;
    logic [1:0] e_st;
    logic       e_ack;
    for (int d = first_d; d <= last_d; d++) begin
      req = hold || (d == pa) || (d == pb) || (d == pc);
      step();
      e_ack = 1'b0;
      if (d < 0) begin
        e_st   = 2'd0;
        e_rstn = 3'b000;
      end else if (d < H) begin
        e_st   = 2'd1;
        e_rstn = 3'b000;
      end else begin
        c = (d - H) / S + 1;
        if (c > N) c = N;
        e_rstn = 3'((1 << c) - 1);
        e_st   = (c == N) ? 2'd3 : 2'd2;
        e_ack  = sw && (d == H + (N - 1) * S);
      end
      check($sformatf("%s d=%0d rstn",  tag, d), 32'(rstn), 32'(e_rstn));
      check($sformatf("%s d=%0d state", tag, d), 32'(st),   32'(e_st));
      check($sformatf("%s d=%0d busy",  tag, d), 32'(busy), 32'(e_st != 2'd3));
      check($sformatf("%s d=%0d ack",   tag, d), 32'(ack),  32'(e_ack));
      if (!sw) begin
        check($sformatf("%s d=%0d rstn_m", tag, d), 32'(rstn_m), 32'(d >= 1));
        check($sformatf("%s d=%0d st_m",   tag, d), 32'(st_m),
              (d < 0) ? 32'd0 : (d == 0) ? 32'd1 : 32'd3);
        check($sformatf("%s d=%0d ack_m",  tag, d), 32'(ack_m), 32'd0);
      end
    end
  endtask

  initial begin
    // Scenario 1: power-on reset; reset values must appear without a clock.
    #1 rst = 1'b1;
    #1 check_all_reset("por_noclk");
    repeat (4) step();
    check_all_reset("por_held");
    rst = 1'b0;
    // A request pulse during RESET must be ignored.
    run_seq(-2, 10, 1'b0, 1'b0, -1, -100, -100, "s1");

    // Scenario 2: single software pulse in RUN.
    run_seq(0, 10, 1'b1, 1'b0, 0, -100, -100, "s2");

    // Scenario 3: request held high across a full sequence -> one sequence only.
    run_seq(0, 12, 1'b1, 1'b1, -100, -100, -100, "s3");
    req = 1'b0;
    step();
    check("s3 tail state", 32'(st),  32'd3);
    check("s3 tail ack",   32'(ack), 32'd0);
    check("s3 tail rstn",  32'(rstn), 32'd7);

    // Scenario 4: extra pulses during HOLD and REL are ignored.
    run_seq(0, 10, 1'b1, 1'b0, 0, 2, 5, "s4");

    // Scenario 5: i_rst mid-clock in REL with o_rstn=001.
    run_seq(0, 5, 1'b1, 1'b0, 0, -100, -100, "s5a");
    #2 rst = 1'b1;
    #1 check_all_reset("s5_async");
    step();
    step();
    check_all_reset("s5_held");
    rst = 1'b0;
    run_seq(-2, 10, 1'b0, 1'b0, -100, -100, -100, "s5b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
